// File: rtl/xswitch_pkg.sv
// Shared types and defaults for the switch fabric blocks.
// Holds the dispatcher slot-state encoding and the default port count and width.
package xswitch_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int XSW_DEF_N = 4;
    localparam int XSW_DEF_W = 32;

endpackage

// File: rtl/xdispatch_pick.sv
// Combinational round-robin picker: lowest set bit of (cand & mask), else of cand.
// nxt_mask has every bit above the picked index set, so the pointer wraps to 0 after N-1.
module xdispatch_pick
    import xswitch_pkg::*;
#(
    parameter int N = XSW_DEF_N
) (
    input  logic [N-1:0] cand,
    input  logic [N-1:0] mask,
    output logic [N-1:0] pick,
    output logic [N-1:0] nxt_mask
);

    logic [N-1:0] masked;
    logic [N-1:0] src;

    assign masked = cand & mask;
    assign src    = (|masked) ? masked : cand;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign pick[gi]     = src[gi];
                assign nxt_mask[gi] = 1'b0;
            end else begin : g_upper
                assign pick[gi]     = src[gi] & ~(|src[gi-1:0]);
                // Bit set when the pick lies strictly below this index.
                assign nxt_mask[gi] = |pick[gi-1:0];
            end
        end
    endgenerate

endmodule

// File: rtl/xrr_dispatch.sv
// 1-to-N round-robin dispatcher with a one-entry registered slot.
// Build option: define XDISPATCH_READY_AWARE_EN to skip sinks that are stalled at capture time.
module xrr_dispatch
    import xswitch_pkg::*;
#(
    parameter int N = XSW_DEF_N,
    parameter int W = XSW_DEF_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] sink_en,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic [N-1:0] m_valid,
    input  logic [N-1:0] m_ready,
    output logic [W-1:0] m_data,
    output logic         busy
);

    slot_state_e  state_q, state_d;
    logic [N-1:0] tgt_q, tgt_d;
    logic [N-1:0] mask_q, mask_d;
    logic [W-1:0] data_q, data_d;
    logic         rdy_q, rdy_d;

    logic [N-1:0] cand;
    logic [N-1:0] pick;
    logic [N-1:0] nxt_mask;
    logic         tgt_ready;
    logic         capture;

`ifdef XDISPATCH_READY_AWARE_EN
    assign cand = (|(sink_en & m_ready)) ? (sink_en & m_ready) : sink_en;
`else
    assign cand = sink_en;
`endif

    xdispatch_pick #(.N(N)) u_pick (
        .cand     (cand),
        .mask     (mask_q),
        .pick     (pick),
        .nxt_mask (nxt_mask)
    );

    assign tgt_ready = |(tgt_q & m_ready);
    assign s_ready   = rdy_q & (|sink_en) & ((state_q == EMPTY) | tgt_ready);
    assign capture   = s_valid & s_ready;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        mask_d  = mask_q;
        data_d  = data_q;
        rdy_d   = 1'b1;
        if (capture) begin
            state_d = FULL;
            tgt_d   = pick;
            data_d  = s_data;
            mask_d  = nxt_mask;
        end else if ((state_q == FULL) && tgt_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            tgt_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
        end
    end

    assign m_valid = (state_q == FULL) ? tgt_q : '0;
    assign m_data  = data_q;
    assign busy    = (state_q == FULL);

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(m_valid));
    // A held beat must not move or change until its sink takes it.
    a_hold: assert property (@(posedge clk) disable iff (!rstn)
        (busy && !tgt_ready) |=> ((m_valid == $past(m_valid)) && (m_data == $past(m_data))));
`endif

endmodule
